// File: rtl/axis_pkg.sv
// Shared scheduler types and round-robin pick helper for axis_m users.
// Purely combinational helpers, no latency, no flow control.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int RR_MAX = 16;

  // First set bit at or above ptr, wrapping modulo n; returns ptr when req is empty.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int                n);
    logic [3:0] idx;
    int         j;
    rr_pick = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      j   = (int'(ptr) + k) % n;
      idx = 4'(j);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick, pointer advances past adv_idx on adv.
// Pick is same-cycle; requesters are held off simply by not being picked.
module rr_arbiter
  import axis_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  input  logic [IDX_W-1:0] adv_idx,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [IDX_W-1:0] rr_ptr;

  assign any  = |req;
  assign pick = IDX_W'(rr_pick(RR_MAX'(req), 4'(rr_ptr), N_REQ));

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rr_ptr <= '0;
    end else if (adv) begin
      rr_ptr <= (adv_idx == IDX_W'(N_REQ - 1)) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axis_m_sched.sv
// Shares one single-beat axis_m between N_REQ requesters, round-robin, one word in flight.
// Grant to m_send is 1 cycle, finish to req_done 1 cycle; requesters wait with req_valid held.
module axis_m_sched
  import axis_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int IDX_W       = $clog2(N_REQ),
  localparam int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_send,
  input  logic                    m_finish,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    timeout
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t      state, state_nxt;
  logic [IDX_W-1:0]  pick;
  logic              any;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] words [N_REQ];

  logic              load;
  logic              m_send_nxt;
  logic              busy_nxt;
  logic [N_REQ-1:0]  req_done_nxt;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .aclk     (aclk),
    .areset_n (areset_n),
    .req      (req_valid),
    .adv      (state == DONE),
    .adv_idx  (grant_idx),
    .pick     (pick),
    .any      (any)
  );

  always_ff @(posedge aclk) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (m_finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    load         = (state == IDLE) && any;
    m_send_nxt   = load;
    busy_nxt     = (state_nxt != IDLE);
    req_done_nxt = '0;
    if (state == WAIT && m_finish) req_done_nxt = N_REQ'(1) << grant_idx;
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      m_send    <= 1'b0;
      busy      <= 1'b0;
      req_done  <= '0;
      grant_idx <= '0;
      m_data    <= '0;
    end else begin
      m_send   <= m_send_nxt;
      busy     <= busy_nxt;
      req_done <= req_done_nxt;
      if (load) begin
        grant_idx <= pick;
        m_data    <= words[pick];
      end
    end
  end

  // No abort on timeout: axis_m cannot cancel a send, so only flag it.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (state == SEND) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !m_finish) begin
      if (wait_cnt == WAIT_MAX) timeout  <= 1'b1;
      else                      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_m_sched.sv
// Randomized bench for axis_m_sched with a transaction-level round-robin model and scoreboard.
module tb_axis_m_sched;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 8;

  logic           aclk = 1'b0;
  logic           areset_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_done;
  logic [W-1:0]   m_data;
  logic           m_send;
  logic           m_finish;
  logic           busy;
  logic [1:0]     grant_idx;
  logic           timeout;

  always #5 aclk = ~aclk;

  axis_m_sched #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TMO)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_done  (req_done),
    .m_data    (m_data),
    .m_send    (m_send),
    .m_finish  (m_finish),
    .busy      (busy),
    .grant_idx (grant_idx),
    .timeout   (timeout)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   ptr_m     = 0;
  bit   tmo_phase = 1'b0;
  bit   withhold  = 1'b0;
  bit   pend      = 1'b0;
  int   cnt       = 0;
  int   fix_dly   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic expired(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // One cycle of requester and axis_m behaviour, inputs driven just after the edge.
  task automatic tick();
    int g;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) if (req_done[i]) req_valid[i] = 1'b0;
    m_finish = 1'b0;
    if (pend) begin
      if (cnt > 1) cnt--;
      else if (!withhold) begin
        m_finish = 1'b1;
        pend     = 1'b0;
      end
    end
    if (m_send) begin
      g = int'(grant_idx);
      if ($urandom_range(1, 0) == 1) begin
        req_valid[g]       = 1'b0;
        req_data[g*W +: W] = $urandom;
      end
      pend = 1'b1;
      cnt  = (fix_dly > 0) ? fix_dly : int'($urandom_range(5, 1));
    end
  endtask

  task automatic wait_quiet();
    int k = 0;
    while (!(req_valid == '0 && !busy && !pend) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) expired("quiet");
    chk("lost_grant", exp_q.size(), 0);
  endtask

  task automatic wait_send();
    int k = 0;
    while (!m_send && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) expired("send");
  endtask

  // All requesters in mask are served once, in circular order from the model pointer.
  task automatic round(input logic [N-1:0] mask, input logic [W-1:0] base);
    int   last;
    exp_t e;
    last = ptr_m;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = (base != '0) ? base : $urandom;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr_m + k) % N;
      if (mask[i]) begin
        e.idx = i;
        e.dat = req_data[i*W +: W];
        exp_q.push_back(e);
        last = i;
      end
    end
    ptr_m     = (last + 1) % N;
    req_valid = mask;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_send"}, m_send, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_idx"}, grant_idx, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  bit           send_prev = 1'b0;
  bit           done_prev = 1'b0;
  bit           fin_prev  = 1'b0;
  bit           rst_q     = 1'b0;
  logic [W-1:0] mdat_prev = '0;

  always @(negedge aclk) begin
    if (areset_n && rst_q) begin
      if (m_send) begin
        chk("send_one_cycle", send_prev, 0);
        chk("send_after_done", done_prev, 0);
        if (exp_q.size() == 0) begin
          expired("unexpected_send");
        end else begin
          cur = exp_q.pop_front();
          chk("grant_idx", grant_idx, cur.idx);
          chk("m_data", m_data, cur.dat);
        end
      end else begin
        chk("m_data_hold", m_data, mdat_prev);
      end
      chk("req_done", req_done, fin_prev ? (W'(1) << cur.idx) : '0);
      if (done_prev) chk("busy_after_done", busy, 0);
      if (!tmo_phase) chk("no_timeout", timeout, 0);
    end
    send_prev = m_send;
    done_prev = |req_done;
    fin_prev  = m_finish;
    mdat_prev = m_data;
    rst_q     = areset_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    m_finish  = 1'b0;
    repeat (2) tick();
    areset_n = 1'b1;
    check_reset("reset");
    tick();

    // Continuous requests from reset: 0,1,2,3 then 0 again.
    round(4'b1111, '0);
    wait_quiet();
    round(4'b1111, '0);
    wait_quiet();

    // Single request with a fixed 3-cycle finish.
    fix_dly = 3;
    round(4'b0100, 32'hDEADBEEF);
    wait_send();
    chk("single_m_data", m_data, 32'hDEADBEEF);
    chk("single_grant", grant_idx, 2);
    wait_quiet();
    fix_dly = 0;

    // Pointer sits past 3, so 0 wins before 3.
    round(4'b1000, '0);
    wait_quiet();
    round(4'b1001, '0);
    wait_quiet();

    for (int r = 0; r < 40; r++) begin
      round(N'($urandom_range(15, 1)), '0);
      wait_quiet();
    end

    // Withheld finish: timeout rises after 8 WAIT cycles, transfer still completes.
    tmo_phase = 1'b1;
    withhold  = 1'b1;
    round(4'b0010, '0);
    wait_send();
    repeat (TMO) tick();
    chk("tmo_early", timeout, 0);
    tick();
    chk("tmo_set", timeout, 1);
    chk("tmo_busy", busy, 1);
    repeat (3) tick();
    chk("tmo_hold", timeout, 1);
    withhold = 1'b0;
    wait_quiet();
    chk("tmo_sticky", timeout, 1);

    // Reset in the middle of WAIT.
    withhold = 1'b1;
    round(4'b0100, '0);
    wait_send();
    repeat (3) tick();
    areset_n = 1'b0;
    tick();
    areset_n  = 1'b1;
    req_valid = '0;
    pend      = 1'b0;
    withhold  = 1'b0;
    exp_q.delete();
    ptr_m     = 0;
    tmo_phase = 1'b0;
    check_reset("midwait");
    tick();
    chk("midwait_no_done", req_done, 0);

    round(4'b1111, '0);
    wait_quiet();
    for (int r = 0; r < 10; r++) begin
      round(N'($urandom_range(15, 1)), '0);
      wait_quiet();
    end
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
